// File: rtl/div_unit_pkg.sv
// Shared defines for the multi-cycle DIV/DIVU unit: FSM encodings, handshake
// levels and the operand magnitude helper used by the signed path.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam logic [5:0] DivSteps = 6'd32;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is correct
    // when read as unsigned.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_unit.sv
// 32-bit restoring divider beside EX: one quotient bit per cycle, result
// {remainder, quotient} held while start_i stays high.
module div_unit
    import div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        busy_o
);

    div_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] dividend_q, dividend_d;
    logic [31:0] divisor_q, divisor_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic        go;
    logic [32:0] diff;
    logic [31:0] quo_fix, rem_fix;

    assign go = (start_i == DivStart) && !annul_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= DivFree;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DivFree:   if (go) state_d = (opdata2_i == 32'd0) ? DivByZero : DivOn;
            DivByZero: state_d = DivEnd;
            DivOn: begin
                if (annul_i)                state_d = DivFree;
                else if (cnt_q == DivSteps) state_d = DivEnd;
            end
            DivEnd:    if (annul_i || start_i == DivStop) state_d = DivFree;
            default:   state_d = DivFree;
        endcase
    end

    assign busy_o = (state_q == DivByZero) || (state_q == DivOn) ||
                    (state_q == DivFree && go);

    assign diff    = {1'b0, dividend_q[63:32]} - {1'b0, divisor_q};
    assign quo_fix = q_neg_q ? (~dividend_q[31:0] + 32'd1) : dividend_q[31:0];
    assign rem_fix = r_neg_q ? (~dividend_q[64:33] + 32'd1) : dividend_q[64:33];

    always_comb begin
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        result_d   = result_q;
        ready_d    = ready_q;
        case (state_q)
            DivFree: begin
                if (go) begin
                    divisor_d  = mag32(opdata2_i, signed_div_i);
                    dividend_d = {32'd0, mag32(opdata1_i, signed_div_i), 1'b0};
                    cnt_d      = 6'd0;
                    q_neg_d    = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                    r_neg_d    = signed_div_i & opdata1_i[31];
                end
            end
            DivByZero: begin
                dividend_d = 65'd0;
                result_d   = 64'd0;
                ready_d    = DivResultReady;
            end
            DivOn: begin
                if (annul_i) begin
                    result_d = 64'd0;
                    cnt_d    = 6'd0;
                end else if (cnt_q != DivSteps) begin
                    // diff[32] set means the trial subtract borrowed: restore by plain shift
                    if (diff[32]) dividend_d = {dividend_q[63:0], 1'b0};
                    else          dividend_d = {diff[31:0], dividend_q[31:0], 1'b1};
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    result_d = {rem_fix, quo_fix};
                    ready_d  = DivResultReady;
                end
            end
            DivEnd: begin
                if (annul_i || start_i == DivStop) begin
                    result_d = 64'd0;
                    ready_d  = DivResultNotReady;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= 6'd0;
            dividend_q <= 65'd0;
            divisor_q  <= 32'd0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            result_q   <= 64'd0;
            ready_q    <= DivResultNotReady;
        end else begin
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: expected results are queued when a division is
// launched and popped when ready_o rises.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i, opdata2_i;
    logic        start_i, annul_i;
    logic [63:0] result_o;
    logic        ready_o, busy_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Launch, wait for ready (bounded), check latency/busy/result, then release.
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp,
                          input int exp_lat, input bit scramble);
        int lat = 0;
        int busy_n = 0;
        logic [63:0] want;
        @(negedge clk);
        signed_div_i = sgn; opdata1_i = a; opdata2_i = b;
        start_i = 1'b1; annul_i = 1'b0;
        exp_q.push_back(exp);
        #1 if (busy_o) busy_n++;
        while (!ready_o && lat < 100) begin
            @(negedge clk);
            lat++;
            if (busy_o) busy_n++;
            if (scramble) begin
                opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~sgn;
            end
        end
        check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "/busy_cycles"}, 64'(busy_n), 64'(exp_lat));
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
        check({tag, "/result"}, result_o, want);
        repeat (2) @(negedge clk);
        check({tag, "/held"}, {ready_o, result_o[62:0]}, {1'b1, want[62:0]});
        start_i = 1'b0;
        @(negedge clk);
        check({tag, "/cleared"}, {63'd0, ready_o} | result_o, 64'd0);
    endtask

    initial begin
        int rdy_n;
        int lat;
        rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = 32'd0; opdata2_i = 32'd0;
        #1;
        check("reset/ready", 64'(ready_o), 64'd0);
        check("reset/result", result_o, 64'd0);
        check("reset/busy", 64'(busy_o), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        do_div("u100_7", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 34, 1'b0);
        do_div("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34, 1'b0);
        do_div("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 34, 1'b0);
        do_div("u_max_1_scr", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, 34, 1'b1);
        do_div("u_div0", 1'b0, 32'd1234, 32'd0, 64'd0, 2, 1'b0);
        do_div("s_div0", 1'b1, 32'hFFFF_0000, 32'd0, 64'd0, 2, 1'b0);
        do_div("s7_m3", 1'b1, 32'd7, 32'hFFFF_FFFD, model(1'b1, 32'd7, 32'hFFFF_FFFD), 34, 1'b0);
        do_div("s-100_-9", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF7,
               model(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF7), 34, 1'b0);
        do_div("u_big", 1'b0, 32'h8765_4321, 32'h0001_2345,
               model(1'b0, 32'h8765_4321, 32'h0001_2345), 34, 1'b0);

        // start and annul together in FREE: nothing launches
        @(negedge clk);
        opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1; annul_i = 1'b1;
        #1 check("start_annul/busy_now", 64'(busy_o), 64'd0);
        @(negedge clk);
        check("start_annul/busy_next", 64'(busy_o), 64'd0);
        start_i = 1'b0; annul_i = 1'b0;

        // annul at step 10, then a clean 9 / 3
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0; start_i = 1'b0;
        #1 check("annul/free", 64'(busy_o), 64'd0);
        rdy_n = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) rdy_n++;
        end
        check("annul/no_ready", 64'(rdy_n), 64'd0);
        check("annul/result", result_o, 64'd0);
        do_div("after_annul_9_3", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 34, 1'b0);

        // asynchronous reset mid-ON
        @(negedge clk);
        signed_div_i = 1'b1; opdata1_i = 32'd1000; opdata2_i = 32'd10; start_i = 1'b1;
        repeat (10) @(negedge clk);
        start_i = 1'b0;
        #1 check("rst_on/busy_before", 64'(busy_o), 64'd1);
        #1 rst = 1'b0;
        #1;
        check("rst_on/busy", 64'(busy_o), 64'd0);
        check("rst_on/ready_result", {63'd0, ready_o} | result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        do_div("after_rst", 1'b1, 32'd1000, 32'hFFFF_FFF6, {32'h0, 32'hFFFF_FF9C}, 34, 1'b0);

        // asynchronous reset while holding a result in END
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1;
        lat = 0;
        while (!ready_o && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("rst_end/result_before", result_o, {32'h0, 32'd10});
        #2 rst = 1'b0;
        #1 check("rst_end/cleared", {63'd0, ready_o} | result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1; start_i = 1'b0;
        @(negedge clk);

        check("scoreboard/empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit divider for the DIV/DIVU instructions, placed beside the execute stage. EX starts a division with `start_i` and holds it asserted. The unit runs one restoring-division step per cycle. It then presents `{remainder, quotient}` for EX to write into HI/LO. EX uses `busy_o` to raise its pipeline stall request, and `annul_i` cancels an in-flight division when the instruction is flushed.

## Interface
Parameters: none. Operand width is fixed at 32.
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU; latched on start
- opdata1_i  in  32  dividend; latched on start
- opdata2_i  in  32  divisor; latched on start
- start_i  in  1  request; EX holds it high until it sees `ready_o`
- annul_i  in  1  cancels the current division
- result_o  out  64  {remainder[63:32] → HI, quotient[31:0] → LO}; valid only while `ready_o` = 1
- ready_o  out  1  result valid
- busy_o  out  1  high in BYZERO and ON, and in FREE when `start_i` = 1 and `annul_i` = 0

## Operation
FSM states: FREE, BYZERO, ON, END.
- **FREE**
  - `start_i` = 1 and `annul_i` = 0: latch `signed_div_i` and both operands.
  - Divisor = 0 → BYZERO; otherwise → ON with `cnt` = 0.
  - In signed mode, latch the magnitudes of negative operands. Also record the dividend sign and the quotient sign (the XOR of the two operand signs).
- **BYZERO**: force the dividend work register to 0 → END.
- **ON**
  - Work register `dividend` is 65 bits, initialised to {32'b0, |op1|, 1'b0}.
  - Each cycle while `cnt` < 32:
    - `diff` = {1'b0, `dividend`[63:32]} − {1'b0, |op2|}, 33 bits.
    - `diff`[32] = 1: `dividend` <= `dividend` << 1.
    - Else: `dividend` <= {`diff`[31:0], `dividend`[31:0], 1'b1}.
    - `cnt`++.
  - When `cnt` = 32:
    - Quotient = `dividend`[31:0], negated if the quotient sign is set.
    - Remainder = `dividend`[64:33], negated if the dividend was negative.
    - Load both into `result_o` and go to END.
  - `annul_i` = 1 takes priority over everything in ON → FREE, `result_o` <= 0.
- **END**
  - `ready_o` = 1; `result_o` is held.
  - `start_i` = 0 → FREE, with `ready_o` and `result_o` cleared at that edge.
  - `start_i` held high keeps the unit in END; it does not restart.
  - `annul_i` = 1 → FREE and clear.
- **Signed corner case**: 0x80000000 / −1 wraps to quotient 0x80000000, remainder 0. No trap is raised.
- **Reset (`rst` = 0, any state, including mid-ON)**: immediately state = FREE, `cnt` = 0, `ready_o` = 0, `busy_o` = 0, `result_o` = 0. The work register is cleared.

## Timing
- All state is registered on `clk`; `busy_o` is the only combinational output.
- Normal division, edge E1 samples start:
  - E1 → ON.
  - E2..E33 perform the 32 steps.
  - E34 → END.
  - `ready_o` is high from E34 until the edge after `start_i` falls.
  - Latency: 34 cycles.
- Divide by zero: E1 → BYZERO, E2 → END. Latency 2 cycles, `result_o` = 0.
- Operand changes after E1 have no effect.
- `start_i` and `annul_i` asserted in the same FREE cycle: no start.
- Back-to-back divisions: at least one FREE cycle between them, because `start_i` must drop first.

## Structure
- State encodings go in the shared defines file: `DivFree` 2'b00, `DivByZero` 2'b01, `DivOn` 2'b10, `DivEnd` 2'b11.
- Also in the defines file: `DivResultReady`, `DivResultNotReady`, `DivStart`, `DivStop`.
- Single module with no sub-module. The 33-bit subtract and the sign fix-up stay inline.

## Test plan
- Unsigned 100 / 7: after 34 cycles `ready_o` = 1 and `result_o` = {32'h00000002, 32'h0000000E}. Dropping `start_i` clears both one cycle later.
- Signed −7 / 2: `result_o` = {32'hFFFFFFFF, 32'hFFFFFFFD}. Signed 0x80000000 / 0xFFFFFFFF: `result_o` = {32'h0, 32'h80000000}.
- Unsigned 0xFFFFFFFF / 1: `result_o` = {32'h0, 32'hFFFFFFFF}. Change `opdata1_i` during ON; the result must not change.
- Divisor 0: `ready_o` rises 2 cycles after start with `result_o` = 0. `busy_o` is high for exactly those 2 cycles.
- `annul_i` pulsed at step 10:
  - FREE at the next edge, and `ready_o` never rises.
  - A new start of 9 / 3 then returns {32'h0, 32'h3}.
- `rst` driven low mid-ON, asynchronously between edges: outputs go to 0 immediately. After release, a fresh start completes normally.
